// File: rtl/moore_seq_detector.sv
// Serial Moore pattern detector: tracks the longest matched prefix of PATTERN
// in the incoming bit stream, flags full matches and counts them (saturating).
module moore_seq_detector #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] PATTERN = 4'b1011,
  parameter bit               OVERLAP = 1'b1,
  parameter int               CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       din,
  input  logic                       clear_cnt,
  output logic                       F,
  output logic [$clog2(WIDTH+1)-1:0] match_len,
  output logic [CNT_W-1:0]           count
);

  localparam int LW = $clog2(WIDTH + 1);
  localparam logic [LW-1:0] FULL = LW'(WIDTH);

  // State k = length of the longest pattern prefix ending at the newest bit.
  typedef logic [LW-1:0] state_t;

  state_t             state_q, state_d;
  logic               f_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [WIDTH-1:0]   pat_sh;
  logic [WIDTH:0]     hist;
  logic [WIDTH:0]     pref;
  logic [WIDTH:0]     mask;
  logic               hit;

  // hist holds the eligible history implied by the current state plus din,
  // newest bit at index 0; the next state is the longest prefix it ends with.
  always_comb begin
    pat_sh  = PATTERN >> (WIDTH - 32'(state_q));
    hist    = {pat_sh, din};
    pref    = '0;
    mask    = '0;
    state_d = '0;
    for (int j = 1; j <= WIDTH; j++) begin
      pref              = '0;
      pref[WIDTH-1:0]   = PATTERN >> (WIDTH - j);
      mask              = ~({(WIDTH + 1){1'b1}} << j);
      if ((j <= 32'(state_q) + 1) && (((hist ^ pref) & mask) == '0))
        state_d = LW'(j);
    end
    if (!OVERLAP && (state_q == FULL))
      state_d = (din == PATTERN[WIDTH-1]) ? LW'(1) : '0;
  end

  always_comb begin
    hit   = (state_d == FULL);
    cnt_d = clear_cnt ? '0 : cnt_q;
    if (hit && (cnt_d != '1))
      cnt_d = cnt_d + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= '0;
      f_q     <= 1'b0;
      cnt_q   <= '0;
    end else if (en) begin
      state_q <= state_d;
      f_q     <= (state_d == FULL);
      cnt_q   <= cnt_d;
    end
  end

  assign F         = f_q;
  assign match_len = state_q;
  assign count     = cnt_q;

endmodule

// File: tb/tb_moore_seq_detector.sv
// Directed bench for moore_seq_detector: four parameterisations share one
// stimulus stream and are checked against hand-computed expectations.
module tb_moore_seq_detector;

  logic clk = 1'b0;
  logic reset, en, din, clear_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic       f_a, f_b, f_c, f_d;
  logic [2:0] ml_a, ml_b, ml_c, ml_d;
  logic [7:0] cnt_a, cnt_b, cnt_d;
  logic [1:0] cnt_c;

  always #5 clk = ~clk;

  moore_seq_detector #(.WIDTH(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) u_a (
    .clk(clk), .reset(reset), .en(en), .din(din), .clear_cnt(clear_cnt),
    .F(f_a), .match_len(ml_a), .count(cnt_a));

  moore_seq_detector #(.WIDTH(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) u_b (
    .clk(clk), .reset(reset), .en(en), .din(din), .clear_cnt(clear_cnt),
    .F(f_b), .match_len(ml_b), .count(cnt_b));

  moore_seq_detector #(.WIDTH(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) u_c (
    .clk(clk), .reset(reset), .en(en), .din(din), .clear_cnt(clear_cnt),
    .F(f_c), .match_len(ml_c), .count(cnt_c));

  moore_seq_detector #(.WIDTH(4), .PATTERN(4'b1111), .OVERLAP(1'b1), .CNT_W(8)) u_d (
    .clk(clk), .reset(reset), .en(en), .din(din), .clear_cnt(clear_cnt),
    .F(f_d), .match_len(ml_d), .count(cnt_d));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: inputs set before the edge, outputs observable 1ns after it.
  task automatic step(input logic r, input logic e, input logic d, input logic c);
    reset = r; en = e; din = d; clear_cnt = c;
    @(posedge clk);
    #1;
  endtask

  task automatic bit_in(input logic d);
    step(1'b0, 1'b1, d, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1, 1'b1, 1'b1);
  endtask

  logic [6:0] s7;
  logic [5:0] s6;
  logic [2:0] exp_a7[7];
  logic [2:0] exp_b7[7];
  logic [2:0] exp_a6[6];
  logic [1:0] exp_cnt_c[5];

  initial begin
    reset = 1'b1; en = 1'b0; din = 1'b0; clear_cnt = 1'b0;
    @(negedge clk);

    // Reset state
    do_reset();
    check("rst_ml", 32'(ml_a), 0);
    check("rst_f", 32'(f_a), 0);
    check("rst_cnt", 32'(cnt_a), 0);

    // Basic 1011
    bit_in(1'b1); check("basic_ml1", 32'(ml_a), 1); check("basic_f1", 32'(f_a), 0);
    bit_in(1'b0); check("basic_ml2", 32'(ml_a), 2);
    bit_in(1'b1); check("basic_ml3", 32'(ml_a), 3);
    bit_in(1'b1); check("basic_ml4", 32'(ml_a), 4); check("basic_f4", 32'(f_a), 1);
    check("basic_cnt", 32'(cnt_a), 1);
    bit_in(1'b0); check("basic_f_drop", 32'(f_a), 0); check("basic_ml5", 32'(ml_a), 2);

    // Overlap vs non-overlap on 1011011
    do_reset();
    s7 = 7'b1011011;
    exp_a7 = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd2, 3'd3, 3'd4};
    exp_b7 = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1, 3'd1};
    for (int i = 0; i < 7; i++) begin
      bit_in(s7[6-i]);
      check($sformatf("ovl_ml_b%0d", i + 1), 32'(ml_a), 32'(exp_a7[i]));
      check($sformatf("novl_ml_b%0d", i + 1), 32'(ml_b), 32'(exp_b7[i]));
      check($sformatf("ovl_f_b%0d", i + 1), 32'(f_a), (i == 3 || i == 6) ? 1 : 0);
    end
    check("ovl_cnt", 32'(cnt_a), 2);
    check("novl_cnt", 32'(cnt_b), 1);

    // Failure fallback 101011
    do_reset();
    s6 = 6'b101011;
    exp_a6 = '{3'd1, 3'd2, 3'd3, 3'd2, 3'd3, 3'd4};
    for (int i = 0; i < 6; i++) begin
      bit_in(s6[5-i]);
      check($sformatf("fb_ml_b%0d", i + 1), 32'(ml_a), 32'(exp_a6[i]));
      check($sformatf("fb_f_b%0d", i + 1), 32'(f_a), (i == 5) ? 1 : 0);
    end

    // Enable gaps
    do_reset();
    bit_in(1'b1);
    bit_in(1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'(i % 2), 1'b0);
      check($sformatf("gap_ml_%0d", i), 32'(ml_a), 2);
      check($sformatf("gap_f_%0d", i), 32'(f_a), 0);
    end
    bit_in(1'b1); check("gap_ml3", 32'(ml_a), 3);
    bit_in(1'b1); check("gap_f", 32'(f_a), 1); check("gap_cnt", 32'(cnt_a), 1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("gap_hold_f", 32'(f_a), 1); check("gap_hold_ml", 32'(ml_a), 4);

    // Saturating counter (CNT_W=2): 1011 then 011 x4, then a cleared 6th match
    do_reset();
    exp_cnt_c = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    bit_in(1'b1);
    for (int m = 0; m < 5; m++) begin
      bit_in(1'b0); bit_in(1'b1); bit_in(1'b1);
      check($sformatf("sat_cnt_m%0d", m + 1), 32'(cnt_c), 32'(exp_cnt_c[m]));
      check($sformatf("sat_f_m%0d", m + 1), 32'(f_c), 1);
    end
    check("wide_cnt", 32'(cnt_a), 5);
    bit_in(1'b0); bit_in(1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check("clr_match_cnt", 32'(cnt_c), 1);
    check("clr_keeps_state", 32'(ml_c), 4);
    bit_in(1'b0);
    check("clr_after_cnt", 32'(cnt_c), 1);

    // Reset mid-pattern
    do_reset();
    bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
    do_reset();
    check("mid_rst_ml", 32'(ml_a), 0);
    check("mid_rst_f", 32'(f_a), 0);
    check("mid_rst_cnt", 32'(cnt_a), 0);
    bit_in(1'b1); check("mid_ml1", 32'(ml_a), 1); check("mid_f1", 32'(f_a), 0);
    bit_in(1'b0); bit_in(1'b1); check("mid_f3", 32'(f_a), 0);
    bit_in(1'b1); check("mid_f4", 32'(f_a), 1); check("mid_cnt", 32'(cnt_a), 1);

    // All-ones pattern, constant 1 stream: F stays high after the 4th bit
    do_reset();
    for (int i = 0; i < 7; i++) begin
      bit_in(1'b1);
      check($sformatf("ones_f_b%0d", i + 1), 32'(f_d), (i >= 3) ? 1 : 0);
    end
    check("ones_cnt", 32'(cnt_d), 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
